sequenciador_microcodigo: RTL and testbench

//  Parametrised, programmable successor of the fixed-sequence datapath controller: drives N_SEL mux

---
 rtl/seq_pkg.sv | 39 +++
 rtl/sequenciador_microcodigo_ucode_ram.sv | 33 +++
 rtl/sequenciador_microcodigo.sv | 132 +++++++++++++
 tb/tb_sequenciador_microcodigo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// Package : seq_pkg
// Brief   : State encoding and microcode word field positions for the
//           microcode sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int sel_msb(input int n_sel, input int sel_w);
        return n_sel * sel_w - 1;
    endfunction

    function automatic int load_lsb(input int n_sel, input int sel_w);
        return n_sel * sel_w;
    endfunction

    function automatic int loop_bit(input int n_sel, input int sel_w, input int n_load);
        return n_sel * sel_w + n_load;
    endfunction

    function automatic int end_bit(input int n_sel, input int sel_w, input int n_load);
        return n_sel * sel_w + n_load + 1;
    endfunction

    function automatic int word_w(input int n_sel, input int sel_w, input int n_load);
        return n_sel * sel_w + n_load + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sequenciador_microcodigo_ucode_ram.sv
// ============================================================================
// Module  : ucode_ram
// Brief   : DEPTH x W microcode store, synchronous write, asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ucode_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 12,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/sequenciador_microcodigo.sv
// ============================================================================
// Module  : sequenciador_microcodigo
// Brief   : Programmable microcode sequencer driving datapath mux selects and
//           register loads, with loop count, abort and start/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sequenciador_microcodigo
    import seq_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int N_SEL     = 3,
    parameter int SEL_W     = 2,
    parameter int N_LOAD    = 4,
    parameter int ITER_W    = 4,
    parameter int LOOP_ADDR = 2,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int W        = word_w(N_SEL, SEL_W, N_LOAD)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio_i,
    input  logic                   abortar_i,
    input  logic [ITER_W-1:0]      n_iter_i,
    input  logic                   prog_we_i,
    input  logic [AW-1:0]          prog_addr_i,
    input  logic [W-1:0]           prog_data_i,
    output logic [N_SEL*SEL_W-1:0] sel_o,
    output logic [N_LOAD-1:0]      load_o,
    output logic                   ocupado_o,
    output logic                   pronto_o,
    output logic                   prog_err_o
);

    localparam int END_BIT  = end_bit(N_SEL, SEL_W, N_LOAD);
    localparam int LOOP_BIT = loop_bit(N_SEL, SEL_W, N_LOAD);
    localparam int LOAD_LSB = load_lsb(N_SEL, SEL_W);
    localparam int SEL_MSB  = sel_msb(N_SEL, SEL_W);
    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LOOP_PC = AW'(LOOP_ADDR);

    state_t              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [ITER_W-1:0]   niter_q, niter_d;
    logic                prog_err_q;
    logic [W-1:0]        ucode_word;
    logic                ram_we;
    logic [ITER_W:0]     iter_inc;

    // The table may only change while no program is executing.
    assign ram_we   = prog_we_i && (state_q == ST_IDLE);
    assign iter_inc = {1'b0, iter_q} + 1'b1;

    ucode_ram #(
        .DEPTH (DEPTH),
        .W     (W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_data_i),
        .raddr_i (pc_q),
        .rdata_o (ucode_word)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        iter_d    = iter_q;
        niter_d   = niter_q;
        sel_o     = '0;
        load_o    = '0;
        ocupado_o = 1'b0;
        pronto_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pc_d   = '0;
                iter_d = '0;
                if (inicio_i) begin
                    state_d = ST_RUN;
                    niter_d = (n_iter_i == '0) ? ITER_W'(1) : n_iter_i;
                end
            end
            ST_RUN: begin
                ocupado_o = 1'b1;
                sel_o     = ucode_word[SEL_MSB:0];
                load_o    = ucode_word[LOAD_LSB +: N_LOAD];
                if (abortar_i) begin
                    state_d = ST_IDLE;
                end else if (ucode_word[END_BIT] || (pc_q == LAST_PC)) begin
                    state_d = ST_DONE;
                end else if (ucode_word[LOOP_BIT] && (iter_inc < {1'b0, niter_q})) begin
                    pc_d   = LOOP_PC;
                    iter_d = iter_inc[ITER_W-1:0];
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_DONE: begin
                pronto_o = 1'b1;
                if (abortar_i || !inicio_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            iter_q     <= '0;
            niter_q    <= '0;
            prog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            iter_q     <= iter_d;
            niter_q    <= niter_d;
            prog_err_q <= prog_we_i && (state_q != ST_IDLE);
        end
    end

    assign prog_err_o = prog_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_microcodigo.sv
// ============================================================================
// Module  : tb_sequenciador_microcodigo
// Brief   : Self-checking bench for the microcode sequencer against a
//           trace-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequenciador_microcodigo;

    localparam int DEPTH     = 16;
    localparam int ITER_W    = 4;
    localparam int LOOP_ADDR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inicio = 1'b0;
    logic        abortar = 1'b0;
    logic [3:0]  n_iter = '0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [11:0] prog_data = '0;
    logic [5:0]  sel;
    logic [3:0]  load;
    logic        ocupado;
    logic        pronto;
    logic        prog_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] ref_mem [DEPTH];
    int          exp_pc [$];

    sequenciador_microcodigo #(
        .DEPTH     (DEPTH),
        .N_SEL     (3),
        .SEL_W     (2),
        .N_LOAD    (4),
        .ITER_W    (ITER_W),
        .LOOP_ADDR (LOOP_ADDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inicio_i    (inicio),
        .abortar_i   (abortar),
        .n_iter_i    (n_iter),
        .prog_we_i   (prog_we),
        .prog_addr_i (prog_addr),
        .prog_data_i (prog_data),
        .sel_o       (sel),
        .load_o      (load),
        .ocupado_o   (ocupado),
        .pronto_o    (pronto),
        .prog_err_o  (prog_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] mk(input bit e, input bit l, input logic [3:0] ld,
                                       input logic [5:0] s);
        return {e, l, ld, s};
    endfunction

    task automatic prog(input int a, input logic [11:0] d);
        prog_we   = 1'b1;
        prog_addr = a[3:0];
        prog_data = d;
        tick();
        prog_we    = 1'b0;
        ref_mem[a] = d;
    endtask

    // Program order as the microcode semantics dictate: one executed address per cycle.
    task automatic build_trace(input int niter);
        int pc = 0;
        int it = 0;
        int n  = (niter == 0) ? 1 : niter;
        exp_pc.delete();
        for (int k = 0; k < 1000; k++) begin
            exp_pc.push_back(pc);
            if (ref_mem[pc][11] || pc == DEPTH - 1) break;
            if (ref_mem[pc][10] && (it + 1 < n)) begin
                pc = LOOP_ADDR;
                it++;
            end else begin
                pc++;
            end
        end
    endtask

    task automatic check_idle(input string nm);
        check_eq({nm, ".ocupado"}, 32'(ocupado), 32'd0);
        check_eq({nm, ".pronto"},  32'(pronto),  32'd0);
        check_eq({nm, ".sel"},     32'(sel),     32'd0);
        check_eq({nm, ".load"},    32'(load),    32'd0);
    endtask

    task automatic run(input int niter, input int abort_idx, input int hold,
                       input bit wr0, input logic [11:0] wr0_data, input string nm);
        n_iter = niter[3:0];
        inicio = 1'b1;
        if (wr0) begin
            prog_we    = 1'b1;
            prog_addr  = '0;
            prog_data  = wr0_data;
            ref_mem[0] = wr0_data;
        end
        build_trace(niter);
        tick();
        prog_we = 1'b0;
        if (hold == 0) inicio = 1'b0;
        n_iter = 4'($urandom);
        foreach (exp_pc[i]) begin
            check_eq($sformatf("%s.ocupado[%0d]", nm, i), 32'(ocupado), 32'd1);
            check_eq($sformatf("%s.pronto[%0d]", nm, i),  32'(pronto),  32'd0);
            check_eq($sformatf("%s.sel[%0d]", nm, i),  32'(sel),  32'(ref_mem[exp_pc[i]][5:0]));
            check_eq($sformatf("%s.load[%0d]", nm, i), 32'(load), 32'(ref_mem[exp_pc[i]][9:6]));
            if (i == abort_idx) begin
                abortar = 1'b1;
                tick();
                abortar = 1'b0;
                inicio  = 1'b0;
                check_idle({nm, ".abort"});
                return;
            end
            tick();
        end
        check_eq({nm, ".done_pronto"},  32'(pronto),  32'd1);
        check_eq({nm, ".done_ocupado"}, 32'(ocupado), 32'd0);
        check_eq({nm, ".done_sel"},     32'(sel),     32'd0);
        check_eq({nm, ".done_load"},    32'(load),    32'd0);
        for (int h = 1; h < hold; h++) begin
            tick();
            check_eq($sformatf("%s.hold_pronto[%0d]", nm, h), 32'(pronto), 32'd1);
        end
        inicio = 1'b0;
        tick();
        check_idle({nm, ".exit"});
    endtask

    initial begin
        int ab;
        int hd;
        rst = 1'b1;
        repeat (3) tick();
        check_idle("reset_held");
        rst = 1'b0;
        tick();
        check_idle("reset");
        check_eq("reset.prog_err", 32'(prog_err), 32'd0);

        for (int a = 0; a < DEPTH; a++) prog(a, 12'h000);
        check_eq("idle_write.prog_err", 32'(prog_err), 32'd0);

        // Straight-line program: one-hot loads, END at address 3.
        prog(0, mk(0, 0, 4'b0001, 6'h15));
        prog(1, mk(0, 0, 4'b0010, 6'h15));
        prog(2, mk(0, 0, 4'b0100, 6'h15));
        prog(3, mk(1, 0, 4'b1000, 6'h15));
        run(1, -1, 0, 0, '0, "basic");

        // Loop body 2..4, LOOP at 4, END at 5.
        prog(0, mk(0, 0, 4'h1, 6'h01));
        prog(1, mk(0, 0, 4'h2, 6'h02));
        prog(2, mk(0, 0, 4'h3, 6'h03));
        prog(3, mk(0, 0, 4'h4, 6'h04));
        prog(4, mk(0, 1, 4'h5, 6'h05));
        prog(5, mk(1, 0, 4'h6, 6'h06));
        run(3, -1, 0, 0, '0, "loop3");
        run(0, -1, 0, 0, '0, "loop0");
        run(2, -1, 0, 0, '0, "loop2");

        run(1, 3, 0, 0, '0, "abort");
        run(1, -1, 0, 0, '0, "restart");

        // Write attempt while running must be dropped and flagged.
        n_iter = 4'd1;
        inicio = 1'b1;
        tick();
        inicio    = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = 12'hFFF;
        tick();
        prog_we = 1'b0;
        check_eq("run_write.prog_err", 32'(prog_err), 32'd1);
        tick();
        check_eq("run_write.prog_err_clear", 32'(prog_err), 32'd0);
        for (int k = 0; k < 50 && !pronto; k++) tick();
        check_eq("run_write.done", 32'(pronto), 32'd1);
        tick();
        run(1, -1, 0, 0, '0, "after_err");

        run(1, -1, 5, 0, '0, "hold");

        // Reset in the middle of a run.
        n_iter = 4'd3;
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_mid");
        tick();
        check_idle("rst_mid_after");

        run(1, -1, 0, 1, mk(0, 0, 4'hA, 6'h2A), "wr_start");

        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                prog(a, mk($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                           4'($urandom), 6'($urandom)));
            end
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            hd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (ab >= 0) hd = 0;
            run(int'($urandom_range(0, 15)), ab, hd, r[0], 12'($urandom),
                $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
